// File: rtl/i2s_capture.sv
// I2S receiver front end: derives scki/bclk/lrck from one free-running counter
// and deserialises din into left/right words, discarding a start-up holdoff.
module i2s_capture #(
  parameter int DATA_W         = 24,
  parameter int STARTUP_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic              scki,
  output logic              bclk,
  output logic              lrck,
  output logic [DATA_W-1:0] left,
  output logic [DATA_W-1:0] right,
  output logic              valid,
  output logic              ready
);

  localparam int FC_W = (STARTUP_FRAMES < 2) ? 1 : $clog2(STARTUP_FRAMES + 1);
  localparam logic [4:0]      LAST_SLOT = 5'(DATA_W);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'((STARTUP_FRAMES > 0) ? STARTUP_FRAMES - 1 : 0);

  logic [8:0]        cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] left_hold;
  logic [FC_W-1:0]   frame_cnt;

  logic [4:0]        slot;
  logic              sample_edge;
  logic              in_word;
  logic              word_done;
  logic [DATA_W-1:0] shift_next;

  // Clock outputs come straight from counter flops, so they cannot glitch.
  assign scki = cnt[0];
  assign bclk = cnt[2];
  assign lrck = cnt[8];

  always_comb begin
    slot        = cnt[7:3];
    sample_edge = (cnt[2:0] == 3'b101);
    in_word     = (slot != 5'd0) && (slot <= LAST_SLOT);
    word_done   = sample_edge && (slot == LAST_SLOT);
    shift_next  = DATA_W'({shift_q, din});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shift_q   <= '0;
      left_hold <= '0;
      left      <= '0;
      right     <= '0;
      valid     <= 1'b0;
      ready     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cnt   <= cnt + 9'd1;
      valid <= 1'b0;

      if (sample_edge && in_word)
        shift_q <= shift_next;

      if (word_done && !cnt[8])
        left_hold <= shift_next;

      // The completing right word is taken from shift_next, which already
      // holds the LSB sampled on this same edge.
      if (word_done && cnt[8]) begin
        if (ready) begin
          left  <= left_hold;
          right <= shift_next;
          valid <= 1'b1;
        end else if (STARTUP_FRAMES != 0) begin
          frame_cnt <= frame_cnt + FC_W'(1);
          if (frame_cnt == FC_LAST)
            ready <= 1'b1;
        end
      end

      if (STARTUP_FRAMES == 0)
        ready <= 1'b1;
    end
  end

endmodule
